// File: rtl/stlatch_pkg.sv
// Shared types and elaboration helpers for the latch strobe sequencer.
package stlatch_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SET  = 2'b01,
        OP_CLR  = 2'b10,
        OP_NOP  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One counter must cover the longest of the three timing windows.
    function automatic int cnt_width(input int s, input int g, input int h);
        return $clog2(max3(s, g, h) + 1);
    endfunction

endpackage

// File: rtl/stlatch_phase_cnt.sv
// Loadable down-counter; o_tc flags the last cycle of the current phase.
module stlatch_phase_cnt
    import stlatch_pkg::*;
#(
    parameter int CW = 1
) (
    input  logic          clock,
    input  logic          resb,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_tc
);

    logic [CW-1:0] r_cnt;

    // Reload on phase entry, otherwise count down and stick at zero.
    always_ff @(posedge clock) begin
        if (!resb) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/stlatch_strobe_gen.sv
// Drive-side sequencer producing s/r/g strobes and d data for a clock-domain latch,
// with a shadow copy of the value the latch is expected to hold.
module stlatch_strobe_gen
    import stlatch_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int SETUP = 1,
    parameter int GATE  = 1,
    parameter int HOLD  = 1
) (
    input  logic             clock,
    input  logic             resb,
    input  logic             req,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             ack,
    output logic             s,
    output logic             r,
    output logic             g,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] shadow
);

    localparam int CW = cnt_width(SETUP, GATE, HOLD);
    // Phases of length N are timed by loading N-1 and leaving on terminal count.
    localparam logic [CW-1:0] LD_SETUP = CW'((SETUP > 0) ? SETUP - 1 : 0);
    localparam logic [CW-1:0] LD_GATE  = CW'((GATE  > 0) ? GATE  - 1 : 0);
    localparam logic [CW-1:0] LD_HOLD  = CW'((HOLD  > 0) ? HOLD  - 1 : 0);

    if (GATE < 1) begin : g_gate_check
        $error("stlatch_strobe_gen: GATE must be at least 1");
    end

    state_t             r_state;
    op_t                r_op;
    logic [WIDTH-1:0]   r_wdata;
    logic               r_busy;
    logic               r_ack;
    logic               r_s;
    logic               r_r;
    logic               r_g;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_shadow;

    state_t             w_state_nxt;
    op_t                w_op_in;
    op_t                w_op_sel;
    logic               w_accept;
    logic               w_load;
    logic [CW-1:0]      w_load_val;
    logic               w_tc;
    logic               w_busy_nxt;
    logic               w_ack_nxt;
    logic               w_s_nxt;
    logic               w_r_nxt;
    logic               w_g_nxt;
    logic [WIDTH-1:0]   w_d_nxt;
    logic [WIDTH-1:0]   w_wdata_nxt;
    logic [WIDTH-1:0]   w_shadow_nxt;

    stlatch_phase_cnt #(
        .CW(CW)
    ) u_phase_cnt (
        .clock      (clock),
        .resb       (resb),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    // Next-state, counter reload and next registered-output values.
    always_comb begin
        w_op_in      = op_t'(op);
        w_accept     = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && req;
        w_op_sel     = w_accept ? w_op_in : r_op;
        w_state_nxt  = ST_IDLE;
        w_load_val   = '0;
        w_shadow_nxt = r_shadow;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    if (w_op_in == OP_NOP) begin
                        w_state_nxt = ST_DONE;
                    end else if (SETUP > 0) begin
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_state_nxt = ST_STROBE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP:  w_state_nxt = w_tc ? ST_STROBE : ST_SETUP;
            ST_STROBE: begin
                if (w_tc) begin
                    w_state_nxt = (HOLD > 0) ? ST_HOLD : ST_DONE;
                end else begin
                    w_state_nxt = ST_STROBE;
                end
            end
            ST_HOLD:   w_state_nxt = w_tc ? ST_DONE : ST_HOLD;
            default:   w_state_nxt = ST_IDLE;
        endcase

        // DONE->DONE on a nop is still a fresh entry, hence the accept term.
        w_load = w_accept || (w_state_nxt != r_state);

        case (w_state_nxt)
            ST_SETUP:  w_load_val = LD_SETUP;
            ST_STROBE: w_load_val = LD_GATE;
            ST_HOLD:   w_load_val = LD_HOLD;
            default:   w_load_val = '0;
        endcase

        w_busy_nxt  = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
                      (w_state_nxt == ST_HOLD);
        w_ack_nxt   = (w_state_nxt == ST_DONE);
        w_g_nxt     = (w_state_nxt == ST_STROBE) && (w_op_sel == OP_LOAD);
        w_s_nxt     = (w_state_nxt == ST_STROBE) && (w_op_sel == OP_SET);
        w_r_nxt     = (w_state_nxt == ST_STROBE) && (w_op_sel == OP_CLR);
        w_d_nxt     = (w_accept && (w_op_in == OP_LOAD)) ? wdata : r_d;
        w_wdata_nxt = w_accept ? wdata : r_wdata;

        // The shadow follows the latch at the edge that ends the strobe.
        if ((r_state == ST_STROBE) && w_tc) begin
            case (r_op)
                OP_LOAD: w_shadow_nxt = r_wdata;
                OP_SET:  w_shadow_nxt = WIDTH'(1'b1);
                OP_CLR:  w_shadow_nxt = '0;
                default: w_shadow_nxt = r_shadow;
            endcase
        end else begin
            w_shadow_nxt = r_shadow;
        end
    end

    // State, captured operation and all outputs are flops.
    always_ff @(posedge clock) begin
        if (!resb) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_NOP;
            r_wdata  <= '0;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
            r_s      <= 1'b0;
            r_r      <= 1'b0;
            r_g      <= 1'b0;
            r_d      <= '0;
            r_shadow <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_sel;
            r_wdata  <= w_wdata_nxt;
            r_busy   <= w_busy_nxt;
            r_ack    <= w_ack_nxt;
            r_s      <= w_s_nxt;
            r_r      <= w_r_nxt;
            r_g      <= w_g_nxt;
            r_d      <= w_d_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

    assign busy   = r_busy;
    assign ack    = r_ack;
    assign s      = r_s;
    assign r      = r_r;
    assign g      = r_g;
    assign d      = r_d;
    assign shadow = r_shadow;

endmodule

// File: tb/tb_stlatch_strobe_gen.sv
// Bench for stlatch_strobe_gen: directed vector table, corner sequences, and a
// randomised run against a cycle-arithmetic reference model plus a latch model.
module tb_stlatch_strobe_gen;
    import stlatch_pkg::*;

    localparam int S = 1;
    localparam int G = 2;
    localparam int H = 1;

    logic       clock = 1'b0;
    logic       resb;
    logic       req;
    logic [1:0] op;
    logic [7:0] wdata;

    logic       busy_a, ack_a, s_a, r_a, g_a;
    logic [7:0] d_a, shadow_a;
    logic       busy_b, ack_b, s_b, r_b, g_b;
    logic [7:0] d_b, shadow_b;

    int checks   = 0;
    int failures = 0;

    stlatch_strobe_gen #(.WIDTH(8), .SETUP(S), .GATE(G), .HOLD(H)) u_dut_a (
        .clock(clock), .resb(resb), .req(req), .op(op), .wdata(wdata),
        .busy(busy_a), .ack(ack_a), .s(s_a), .r(r_a), .g(g_a),
        .d(d_a), .shadow(shadow_a)
    );

    stlatch_strobe_gen #(.WIDTH(8), .SETUP(0), .GATE(1), .HOLD(0)) u_dut_b (
        .clock(clock), .resb(resb), .req(req), .op(op), .wdata(wdata),
        .busy(busy_b), .ack(ack_b), .s(s_b), .r(r_b), .g(g_b),
        .d(d_b), .shadow(shadow_b)
    );

    always #5 clock = ~clock;

    // Behavioural latch driven by DUT A strobes; keeps its value through reset.
    logic [7:0] q;
    always @(posedge clock) begin
        if (g_a)      q <= d_a;
        else if (s_a) q <= 8'h01;
        else if (r_a) q <= 8'h00;
    end

    typedef struct {
        logic        req;
        logic [1:0]  op;
        logic [7:0]  wdata;
        logic [20:0] exp;   // {busy, ack, s, r, g, d, shadow}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rq, input logic [1:0] o, input logic [7:0] w,
                       input logic [4:0] ctl, input logic [7:0] dd, input logic [7:0] sh);
        vec_t v;
        v.req = rq; v.op = o; v.wdata = w; v.exp = {ctl, dd, sh};
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_a();
        return {11'd0, busy_a, ack_a, s_a, r_a, g_a, d_a, shadow_a};
    endfunction

    function automatic logic [31:0] obs_b();
        return {11'd0, busy_b, ack_b, s_b, r_b, g_b, d_b, shadow_b};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model state for the randomised run (DUT A timing).
    int         m_a, m_len, m_free, e, n_acc, cyc, c;
    logic [1:0] m_op;
    logic [7:0] m_w, m_sh, m_d;
    logic       x_busy, x_ack, x_stb;
    logic       got_ack;

    initial begin
        resb = 1'b0; req = 1'b0; op = OP_NOP; wdata = 8'h00;
        tick();
        tick();
        check("reset_a", obs_a(), 32'd0);
        check("reset_b", obs_b(), 32'd0);
        resb = 1'b1;

        // Load 0xA5
        add(1'b1, OP_LOAD, 8'hA5, 5'b10000, 8'hA5, 8'h00);
        add(1'b0, OP_LOAD, 8'h00, 5'b10001, 8'hA5, 8'h00);
        add(1'b0, OP_LOAD, 8'h00, 5'b10001, 8'hA5, 8'h00);
        add(1'b0, OP_LOAD, 8'h00, 5'b10000, 8'hA5, 8'hA5);
        add(1'b0, OP_LOAD, 8'h00, 5'b01000, 8'hA5, 8'hA5);
        add(1'b0, OP_LOAD, 8'h00, 5'b00000, 8'hA5, 8'hA5);
        // Set then clear back-to-back with req held; d must not move
        add(1'b1, OP_SET,  8'h11, 5'b10000, 8'hA5, 8'hA5);
        add(1'b1, OP_CLR,  8'h22, 5'b10100, 8'hA5, 8'hA5);
        add(1'b1, OP_CLR,  8'h22, 5'b10100, 8'hA5, 8'hA5);
        add(1'b1, OP_CLR,  8'h22, 5'b10000, 8'hA5, 8'h01);
        add(1'b1, OP_CLR,  8'h22, 5'b01000, 8'hA5, 8'h01);
        add(1'b1, OP_CLR,  8'h22, 5'b10000, 8'hA5, 8'h01);
        add(1'b0, OP_NOP,  8'h00, 5'b10010, 8'hA5, 8'h01);
        add(1'b0, OP_NOP,  8'h00, 5'b10010, 8'hA5, 8'h01);
        add(1'b0, OP_NOP,  8'h00, 5'b10000, 8'hA5, 8'h00);
        add(1'b0, OP_NOP,  8'h00, 5'b01000, 8'hA5, 8'h00);
        add(1'b0, OP_NOP,  8'h00, 5'b00000, 8'hA5, 8'h00);
        // Nop, then a load with a request pulse while busy
        add(1'b1, OP_NOP,  8'h33, 5'b01000, 8'hA5, 8'h00);
        add(1'b0, OP_NOP,  8'h00, 5'b00000, 8'hA5, 8'h00);
        add(1'b1, OP_LOAD, 8'h5A, 5'b10000, 8'h5A, 8'h00);
        add(1'b0, OP_NOP,  8'h00, 5'b10001, 8'h5A, 8'h00);
        add(1'b0, OP_NOP,  8'h00, 5'b10001, 8'h5A, 8'h00);
        add(1'b1, OP_SET,  8'h00, 5'b10000, 8'h5A, 8'h5A);
        add(1'b0, OP_NOP,  8'h00, 5'b01000, 8'h5A, 8'h5A);
        add(1'b0, OP_NOP,  8'h00, 5'b00000, 8'h5A, 8'h5A);
        add(1'b0, OP_NOP,  8'h00, 5'b00000, 8'h5A, 8'h5A);

        for (int i = 0; i < tbl.size(); i++) begin
            req = tbl[i].req; op = tbl[i].op; wdata = tbl[i].wdata;
            tick();
            check($sformatf("vec%0d", i), obs_a(), {11'd0, tbl[i].exp});
            if (tbl[i].exp[19]) check($sformatf("vec%0d_q", i), {24'd0, q}, {24'd0, shadow_a});
        end

        // Reset during the first strobe cycle of a load, with req present
        req = 1'b1; op = OP_LOAD; wdata = 8'h3C;
        tick();
        check("rst_c1", obs_a(), {11'd0, 5'b10000, 8'h3C, 8'h5A});
        req = 1'b0;
        tick();
        check("rst_c2", obs_a(), {11'd0, 5'b10001, 8'h3C, 8'h5A});
        resb = 1'b0; req = 1'b1; op = OP_CLR;
        tick();
        check("rst_c3", obs_a(), 32'd0);
        resb = 1'b1;
        tick();
        check("rst_c4", obs_a(), {11'd0, 5'b10000, 8'h00, 8'h00});
        req = 1'b0;
        got_ack = 1'b0;
        for (int k = 0; k < 10 && !got_ack; k++) begin
            tick();
            if (ack_a) begin
                got_ack = 1'b1;
                check("rst_realign_q", {24'd0, q}, 32'd0);
                check("rst_realign_sh", {24'd0, shadow_a}, 32'd0);
            end
        end
        check("rst_ack_seen", {31'd0, got_ack}, 32'd1);

        // Minimum windows on DUT B
        for (int k = 0; k < 6; k++) tick();
        req = 1'b1; op = OP_LOAD; wdata = 8'hFF;
        tick();
        check("min_c1", obs_b(), {11'd0, 5'b10001, 8'hFF, 8'h00});
        req = 1'b0;
        tick();
        check("min_c2", obs_b(), {11'd0, 5'b01000, 8'hFF, 8'hFF});
        for (int k = 0; k < 8; k++) tick();

        // Randomised run against the arithmetic model
        resb = 1'b0;
        tick();
        resb = 1'b1;
        m_a = -1000; m_len = 0; m_free = 0; e = 0; n_acc = 0; cyc = 0;
        m_op = OP_NOP; m_w = 8'h00; m_sh = 8'h00; m_d = 8'h00;
        while (n_acc < 1000 && cyc < 20000) begin
            req   = ($urandom_range(0, 2) != 0);
            op    = (n_acc == 0) ? OP_CLR : 2'($urandom_range(0, 3));
            wdata = 8'($urandom);
            if (req && e >= m_free) begin
                m_a = e; m_op = op; m_w = wdata;
                m_len  = (op == OP_NOP) ? 1 : S + G + H + 1;
                m_free = e + m_len;
                if (op == OP_LOAD) m_d = wdata;
                n_acc++;
            end
            c = e + 1;
            if (m_op != OP_NOP && c == m_a + S + G + 1) begin
                if (m_op == OP_LOAD)     m_sh = m_w;
                else if (m_op == OP_SET) m_sh = 8'h01;
                else                     m_sh = 8'h00;
            end
            x_busy = (c > m_a) && (c < m_a + m_len);
            x_ack  = (c == m_a + m_len);
            x_stb  = (m_op != OP_NOP) && (c > m_a + S) && (c <= m_a + S + G);
            tick();
            check("rand", obs_a(), {11'd0, x_busy, x_ack, x_stb && m_op == OP_SET,
                  x_stb && m_op == OP_CLR, x_stb && m_op == OP_LOAD, m_d, m_sh});
            check("rand_excl", {31'd0, ($countones({s_a, r_a, g_a}) <= 1)}, 32'd1);
            if (ack_a) check("rand_q", {24'd0, q}, {24'd0, shadow_a});
            e++;
            cyc++;
        end
        check("rand_ops_done", (n_acc >= 1000) ? 32'd1 : 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
